// File: rtl/program_loader.sv
// Program loader for the SAP-1 16x8 RAM: accepts a DEPTH-byte image plus a
// trailing mod-256 checksum from a valid/ready byte source, holding the CPU in reset until it verifies.
module program_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              Clock_i,
    input  logic              Clear_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   count_o
);
    localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;

    state_t            state_q;
    logic [ADDR_W:0]   count_q;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q, ready_q, hold_q, busy_q, done_q, error_q;
    logic              accept;

    assign accept = in_valid_i & ready_q;
    assign sum_d  = sum_q + in_data_i;

    // All outputs are registered from the next state, so in_ready tracks state entry exactly.
    always_ff @(posedge Clock_i) begin
        if (Clear_i) begin
            state_q <= IDLE;
            count_q <= '0;
            sum_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        state_q <= LOAD;
                        count_q <= '0;
                        sum_q   <= '0;
                        ready_q <= 1'b1;
                        hold_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        we_q    <= 1'b1;
                        addr_q  <= count_q[ADDR_W-1:0];
                        wdata_q <= in_data_i;
                        sum_q   <= sum_d;
                        count_q <= count_q + 1'b1;
                        if (count_q == LAST_CNT) state_q <= CHECK;
                    end
                end
                CHECK: begin
                    // The byte taken here is the checksum; it never reaches RAM.
                    if (accept) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        if (in_data_i == sum_q) begin
                            state_q <= DONE;
                            hold_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = ready_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign cpu_hold_o  = hold_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign count_o     = count_q;
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected RAM writes are queued at each
// accepted byte and matched against mem_we pulses, including their cycle.
module tb_program_loader;
    logic       clk = 1'b0;
    logic       clr, start, in_valid;
    logic [7:0] in_data;
    logic       in_ready, mem_we, cpu_hold, busy, done, error;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [4:0] count;

    program_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .Clock_i(clk), .Clear_i(clr), .start_i(start), .in_data_i(in_data),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .cpu_hold_o(cpu_hold),
        .busy_o(busy), .done_o(done), .error_o(error), .count_o(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    wr_t        sb[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         exp_cnt = 0;
    logic [7:0] img[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every mem_we pulse must match the oldest queued accept, one cycle after it.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) chk("spurious_we", 1, 0);
            else begin
                wr_t w;
                w = sb.pop_front();
                chk("wr_addr", mem_addr, w.addr);
                chk("wr_data", mem_wdata, w.data);
                chk("wr_cycle", cyc, w.cyc);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte and wait (bounded) for it to be accepted.
    task automatic send(input logic [7:0] d, input bit is_data, input int gapmax);
        int gap;
        int n;
        gap = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
        @(negedge clk);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (is_data) begin
            sb.push_back('{addr: exp_cnt[3:0], data: d, cyc: cyc + 1});
            exp_cnt++;
        end
    endtask

    task automatic load(input logic [7:0] cks, input int gapmax);
        pulse_start();
        exp_cnt = 0;
        chk("ready_after_start", in_ready, 1);
        chk("busy_after_start", busy, 1);
        chk("hold_after_start", cpu_hold, 1);
        chk("count_after_start", count, 0);
        for (int i = 0; i < 16; i++) send(img[i], 1'b1, gapmax);
        send(cks, 1'b0, gapmax);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ready_after_cks", in_ready, 0);
        chk("busy_after_cks", busy, 0);
        chk("count_after_cks", count, 16);
        chk("sb_drained", sb.size(), 0);
    endtask

    function automatic logic [7:0] csum();
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 16; i++) s = s + img[i];
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        chk("rst_ready", in_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_count", count, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);

        // Clean load, checksum 0x78.
        for (int i = 0; i < 16; i++) img[i] = 8'(i);
        chk("model_csum", csum(), 8'h78);
        load(8'h78, 0);
        chk("clean_done", done, 1);
        chk("clean_hold", cpu_hold, 0);
        chk("clean_error", error, 0);

        // Bad checksum, then a clean reload from ERR.
        load(8'h77, 0);
        chk("bad_error", error, 1);
        chk("bad_hold", cpu_hold, 1);
        chk("bad_done", done, 0);
        load(8'h78, 0);
        chk("reload_done", done, 1);
        chk("reload_error", error, 0);

        // Gapped source with a random image.
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(255, 0));
        load(csum(), 3);
        chk("gap_done", done, 1);
        chk("gap_hold", cpu_hold, 0);

        // All-0xFF image wraps the sum to 0xF0; then a 17th 0xFF is the checksum.
        for (int i = 0; i < 16; i++) img[i] = 8'hFF;
        load(8'hF0, 0);
        chk("wrap_done", done, 1);
        load(8'hFF, 0);
        chk("ovf_error", error, 1);
        chk("ovf_done", done, 0);

        // Abort after 7 bytes: the in-flight write lands, nothing after Clear.
        for (int i = 0; i < 16; i++) img[i] = 8'(8'hA0 + i);
        pulse_start();
        exp_cnt = 0;
        for (int i = 0; i < 7; i++) send(img[i], 1'b1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("abort_we", mem_we, 0);
        chk("abort_ready", in_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_hold", cpu_hold, 0);
        chk("abort_count", count, 0);
        chk("abort_sb", sb.size(), 0);

        // Clear and start together: Clear wins.
        @(negedge clk);
        clr = 1'b1; start = 1'b1;
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        chk("clr_start_ready", in_ready, 0);
        chk("clr_start_busy", busy, 0);

        // Fresh start writes from address 0; a start mid-load is ignored.
        pulse_start();
        exp_cnt = 0;
        for (int i = 0; i < 5; i++) send(img[i], 1'b1, 0);
        pulse_start();
        chk("ign_start_count", count, 5);
        chk("ign_start_busy", busy, 1);
        for (int i = 5; i < 16; i++) send(img[i], 1'b1, 0);
        send(csum(), 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ign_done", done, 1);
        chk("ign_count", count, 16);

        repeat (3) @(negedge clk);
        chk("final_sb", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
